// File: rtl/sif_pkg.sv
// Shared definitions for the SIF XA/WA buffer: the operation decode and the
// bit positions of the XA status word.
package sif_pkg;

    // The encoding is the concatenation {rst_n, xa_wr_s, xa_rd_s}.
    typedef enum logic [2:0] {
        OP_RESET   = 3'b000,
        OP_IDLE    = 3'b100,
        OP_READ    = 3'b101,
        OP_WRITE   = 3'b110,
        OP_ILLEGAL = 3'b111
    } e_operation_t;

    localparam int STAT_OVF     = 15;
    localparam int STAT_ILL     = 14;
    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_CNT_W   = 8;

    function automatic e_operation_t op_decode(input logic rst_n,
                                               input logic wr,
                                               input logic rd);
        if (!rst_n) begin
            return OP_RESET;
        end
        case ({wr, rd})
            2'b10:   return OP_WRITE;
            2'b01:   return OP_READ;
            2'b11:   return OP_ILLEGAL;
            default: return OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sif_fifo.sv
// Show-ahead FIFO: the head word is always visible on o_data. A push while full
// is taken only if a pop happens in the same cycle.
module sif_fifo
    import sif_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Storage is cleared on reset so the head word reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sif_xa_wa_buffer.sv
// XA-to-WA buffer stage: decodes XA strobes, pushes writes into a show-ahead
// FIFO, answers status reads and keeps sticky overflow/illegal flags.
module sif_xa_wa_buffer
    import sif_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              xa_wr_s,
    input  logic              xa_rd_s,
    input  logic [DATA_W-1:0] xa_data_in,
    output logic [DATA_W-1:0] xa_data_out,
    output logic              xa_rd_valid,
    output logic              xa_err,
    output logic [DATA_W-1:0] wa_data,
    output logic              wa_valid,
    input  logic              wa_ready,
    output logic              full,
    output logic              empty
);

    e_operation_t      w_op;
    logic              w_is_write;
    logic              w_is_read;
    logic              w_is_illegal;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_evt;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_status;

    logic              r_ovf;
    logic              r_ill;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_data_out;

    assign w_op         = op_decode(rst_n, xa_wr_s, xa_rd_s);
    assign w_is_write   = (w_op == OP_WRITE);
    assign w_is_read    = (w_op == OP_READ);
    assign w_is_illegal = (w_op == OP_ILLEGAL);

    // A write into a full FIFO survives only when the consumer frees a slot now.
    assign w_pop     = !w_empty && wa_ready;
    assign w_push    = w_is_write && (!w_full || w_pop);
    assign w_ovf_evt = w_is_write && w_full && !w_pop;

    sif_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (xa_data_in),
        .o_data  (wa_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_status = '0;
        w_status[STAT_OVF] = r_ovf;
        w_status[STAT_ILL] = r_ill;
        w_status[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(w_count);
    end

    // Reads clear the flags they report; a read cycle cannot carry a new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf      <= 1'b0;
            r_ill      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_rd_valid <= w_is_read;
            if (w_is_read) begin
                r_data_out <= w_status;
                r_ovf      <= 1'b0;
                r_ill      <= 1'b0;
            end else begin
                if (w_ovf_evt) begin
                    r_ovf <= 1'b1;
                end
                if (w_is_illegal) begin
                    r_ill <= 1'b1;
                end
            end
        end
    end

    assign xa_data_out = r_data_out;
    assign xa_rd_valid = r_rd_valid;
    assign xa_err      = r_ovf | r_ill;
    assign wa_valid    = !w_empty;
    assign full        = w_full;
    assign empty       = w_empty;

endmodule

// File: doc/sif_xa_wa_buffer.md
Name: sif_xa_wa_buffer

Overview:
- RTL stage between the SIF XA-side driver interface and the WA-side consumer.
- Accepts 16-bit XA write strobes into a small show-ahead FIFO and presents the words on WA with a valid/ready handshake.
- Answers XA read strobes with a status word carrying fill level and sticky error flags.
- Detects the ILLEGAL operation (both strobes high) and FIFO overflow.

Parameters:
- DATA_W, 16, XA/WA data width; status word is also DATA_W bits, minimum 16.
- DEPTH, 4, FIFO depth; power of 2, at least 2.
- CNT_W, $clog2(DEPTH)+1, derived localparam: occupancy counter width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- xa_wr_s  in  1  XA write strobe, one word per high cycle.
- xa_rd_s  in  1  XA read strobe, one status read per high cycle.
- xa_data_in  in  DATA_W  write data, sampled when xa_wr_s=1.
- xa_data_out  out  DATA_W  status word, valid when xa_rd_valid=1.
- xa_rd_valid  out  1  one-cycle pulse, one cycle after an accepted read.
- xa_err  out  1  OR of the sticky flags.
- wa_data  out  DATA_W  FIFO head word.
- wa_valid  out  1  FIFO not empty.
- wa_ready  in  1  consumer accepts the word when wa_valid && wa_ready.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset (async assert, sync-released use): FIFO pointers=0, count=0, sticky flags=0. Outputs: xa_data_out=0, xa_rd_valid=0, xa_err=0, wa_valid=0, wa_data=0 (storage cleared), full=0, empty=1.
- Reset mid-operation discards FIFO content; nothing is flushed to WA.
- Operation decode uses {rst_n, xa_wr_s, xa_rd_s}:
  - 110 WRITE, 101 READ, 100 IDLE.
  - 111 ILLEGAL: no push, no read response, illegal_flag set.
- WRITE:
  - Push is accepted if !full, or if full and a WA pop happens in the same cycle (simultaneous push+pop when full is legal; count unchanged).
  - Otherwise the word is dropped and overflow_flag is set.
- Latency: a word written in cycle N appears on wa_data with wa_valid=1 in cycle N+1 when the FIFO was empty (show-ahead).
- WA handshake:
  - Pop occurs on wa_valid && wa_ready.
  - wa_data is held stable while wa_valid && !wa_ready.
  - wa_ready while empty has no effect.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count saturates by construction (0..DEPTH).
- READ: in cycle N+1, xa_rd_valid=1 and xa_data_out = {overflow_flag, illegal_flag, zeros, count zero-extended into [7:0]}, sampled at cycle N. Bits [DATA_W-1:DATA_W-2] are defined only for DATA_W=16; otherwise bit15=overflow, bit14=illegal.
- xa_data_out holds its last value when xa_rd_valid=0.
- Read-to-clear: flags reported by a read are cleared at the end of cycle N. An overflow or illegal event in the same cycle as the read is not possible for illegal (111 is not a read). For overflow, it cannot coincide because wr/rd are exclusive.
- Sticky flags persist until the next accepted READ or reset. xa_err = overflow_flag | illegal_flag, registered.

Decomposition:
- Shared package sif_pkg:
  - E_Operation-compatible enum for {rst_n, wr, rd} (WRITE, READ, IDLE, ILLEGAL, RESET).
  - Status bit position constants: STAT_OVF=15, STAT_ILL=14, STAT_CNT_LSB=0, STAT_CNT_W=8.
- Sub-module sif_fifo: parameterised DATA_W/DEPTH show-ahead FIFO with push/pop, count, full, empty.
- The top level holds the op decode, sticky flags and read response register.

Test Plan:
1. Reset, write 0x1234 with wa_ready=0 -> next cycle wa_valid=1, wa_data=0x1234, empty=0; count 1.
2. Write 0xA001..0xA004 with wa_ready=0, then write 0xA005 -> full=1, 0xA005 dropped, xa_err=1. READ -> xa_data_out=0x8004 one cycle later. Second READ -> 0x0004, xa_err=0.
3. FIFO full; write 0xBEEF while wa_ready=1 -> 0xA001 popped, 0xBEEF accepted, full stays 1, no overflow. Drain order: A002, A003, A004, BEEF.
4. Drive xa_wr_s=xa_rd_s=1 with xa_data_in=0x5555 -> no push, no xa_rd_valid. Next READ returns 0x4000|count.
5. wa_ready toggling 1/0 during a 6-word burst at DEPTH=4 with pops keeping pace -> all words delivered in order, wa_data stable during stalls.
6. Assert rst_n low mid-burst with count=3 -> outputs return to reset values asynchronously; after release, empty=1 and no stale data appears on WA.
